// File: rtl/cpu_pkg.sv
// Shared types and default constants for the instruction fetch front end.
package cpu_pkg;

   localparam int          XLEN_DEF      = 32;
   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests words over valid/ready and holds
// each returned instruction until decode consumes it; supports redirect and halt.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] PC_STEP      = XLEN'(1),
   parameter logic [XLEN-1:0] HALT_WORD    = XLEN'(HALT_WORD_DEF),
   parameter int              CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [XLEN-1:0]  imem_rsp_data,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             instr_valid,
   output logic [XLEN-1:0]  instr,
   output logic [XLEN-1:0]  instr_pc,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] instr_pc_q;
   logic            squash_q;
   logic            req_valid_q;
   logic            instr_valid_q;
   logic            halted_q;

   logic            req_fire;
   logic            consume;

   assign req_fire = req_valid_q & imem_req_ready;
   // instr_valid_q is only ever set in HOLD for a non-halt word
   assign consume  = (state_q == HOLD) & instr_valid_q & ~stall & ~redirect_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= REQ;
         pc_q          <= RESET_VECTOR;
         fetch_pc_q    <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         squash_q      <= 1'b0;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         case (state_q)
            REQ: begin
               if (req_fire) begin
                  fetch_pc_q  <= pc_q;
                  squash_q    <= redirect_valid;
                  req_valid_q <= 1'b0;
                  state_q     <= WAIT;
               end else begin
                  req_valid_q <= 1'b1;
               end
               if (redirect_valid) begin
                  pc_q <= redirect_pc;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  squash_q <= 1'b0;
                  if (squash_q || redirect_valid) begin
                     req_valid_q <= 1'b1;
                     state_q     <= REQ;
                  end else begin
                     instr_q       <= imem_rsp_data;
                     instr_pc_q    <= fetch_pc_q;
                     instr_valid_q <= (imem_rsp_data != HALT_WORD);
                     state_q       <= HOLD;
                  end
               end else if (redirect_valid) begin
                  squash_q <= 1'b1;
               end
               if (redirect_valid) begin
                  pc_q <= redirect_pc;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc_q          <= redirect_pc;
                  instr_valid_q <= 1'b0;
                  req_valid_q   <= 1'b1;
                  state_q       <= REQ;
               end else if (instr_q == HALT_WORD) begin
                  halted_q <= 1'b1;
                  state_q  <= HALTED;
               end else if (!stall) begin
                  pc_q          <= instr_pc_q + PC_STEP;
                  instr_valid_q <= 1'b0;
                  req_valid_q   <= 1'b1;
                  state_q       <= REQ;
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q <= REQ;
            end
         endcase
      end
   end

   saturating_counter #(
      .WIDTH(CNT_W)
   ) u_instr_count (
      .clk_i  (clock),
      .rst_ni (reset),
      .en_i   (consume),
      .count_o(instr_count)
   );

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign instr_valid    = instr_valid_q;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level reference model of the fetch front end.
module tb_fetch_unit;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   always #5 clock = ~clock;

   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_addr, imem_rsp_data;
   logic        stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, halted;
   logic [31:0] instr, instr_pc;
   logic [15:0] instr_count;

   logic        req_valid4, req_ready4, rsp_valid4, stall4, redirect_valid4;
   logic [31:0] addr4, rsp_data4, redirect_pc4;
   logic        instr_valid4, halted4;
   logic [31:0] instr4, instr_pc4;
   logic [1:0]  instr_count4;

   fetch_unit u_dut (
      .clock(clock), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .halted(halted), .instr_count(instr_count)
   );

   fetch_unit #(
      .PC_STEP(32'd4), .CNT_W(2), .RESET_VECTOR(32'hFFFF_FFFC)
   ) u_dut4 (
      .clock(clock), .reset(reset),
      .imem_req_valid(req_valid4), .imem_req_ready(req_ready4), .imem_addr(addr4),
      .imem_rsp_valid(rsp_valid4), .imem_rsp_data(rsp_data4),
      .stall(stall4), .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
      .instr_valid(instr_valid4), .instr(instr4), .instr_pc(instr_pc4),
      .halted(halted4), .instr_count(instr_count4)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference model: architectural PC, one outstanding fetch, one held word
   logic [31:0] pc_m, out_addr, held_addr, held_data, halt_addr;
   bit          outstanding, out_disc, held, halted_m, post_reset;
   int unsigned cnt_m;
   logic [31:0] consumed[$];

   bit          use_prog;
   logic [31:0] prog[4];
   bit          mem_pend;
   logic [31:0] mem_addr;
   int unsigned mem_delay, lat_min, lat_max;

   logic [31:0] acc4[$];
   bit          acc4_prev;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (use_prog && a < 4) return prog[a[1:0]];
      if (a == halt_addr) return HALT;
      return {8'h13, a[23:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_mem();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mem_pend) begin
         if (mem_delay <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_pend       = 1'b0;
         end else begin
            mem_delay--;
         end
      end
   endtask

   // Called just after a falling edge with this cycle's inputs already driven.
   task automatic cycle();
      bit req_e, acc, was_held, held_halt;
      req_e     = !halted_m && !held && !outstanding && !post_reset;
      held_halt = held && (held_data == HALT);
      chk("req_valid", imem_req_valid, req_e);
      if (req_e) chk("imem_addr", imem_addr, pc_m);
      chk("instr_valid", instr_valid, held && !held_halt);
      if (held && !held_halt) begin
         chk("instr", instr, held_data);
         chk("instr_pc", instr_pc, held_addr);
      end
      chk("halted", halted, halted_m);
      chk("instr_count", instr_count, cnt_m);

      acc        = req_e && imem_req_ready;
      was_held   = held;
      post_reset = 1'b0;
      if (!halted_m) begin
         if (acc) begin
            outstanding = 1'b1;
            out_addr    = pc_m;
            out_disc    = redirect_valid;
            mem_pend    = 1'b1;
            mem_addr    = pc_m;
            mem_delay   = $urandom_range(lat_max, lat_min);
         end else if (outstanding && imem_rsp_valid) begin
            outstanding = 1'b0;
            if (!out_disc && !redirect_valid) begin
               held      = 1'b1;
               held_addr = out_addr;
               held_data = mem_word(out_addr);
            end
         end else if (outstanding && redirect_valid) begin
            out_disc = 1'b1;
         end
         if (was_held) begin
            if (redirect_valid) begin
               held = 1'b0;
            end else if (held_halt) begin
               held     = 1'b0;
               halted_m = 1'b1;
            end else if (!stall) begin
               held = 1'b0;
               pc_m = held_addr + 32'd1;
               consumed.push_back(held_addr);
               if (cnt_m != 32'hFFFF) cnt_m++;
            end
         end
         if (redirect_valid) pc_m = redirect_pc;
      end

      rsp_valid4 = acc4_prev;
      rsp_data4  = 32'h0000_0013;
      acc4_prev  = req_valid4;
      if (req_valid4) acc4.push_back(addr4);

      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset(input bit keep_mem);
      reset          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      rsp_valid4     = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_count", instr_count, 0);
      @(posedge clock);
      @(negedge clock);
      reset       = 1'b1;
      pc_m        = '0;
      outstanding = 1'b0;
      out_disc    = 1'b0;
      held        = 1'b0;
      halted_m    = 1'b0;
      cnt_m       = 0;
      post_reset  = 1'b1;
      acc4_prev   = 1'b0;
      consumed.delete();
      acc4.delete();
      if (!keep_mem) mem_pend = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive_mem();
         cycle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          found;
      logic [15:0] c0;
      req_ready4 = 1'b1; stall4 = 1'b0; redirect_valid4 = 1'b0; redirect_pc4 = '0;
      rsp_valid4 = 1'b0; rsp_data4 = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      prog[0] = 32'h0050_0093; prog[1] = 32'h0010_8133;
      prog[2] = 32'h0000_A183; prog[3] = HALT;
      use_prog = 1'b1; halt_addr = 32'hFFFF_0000; lat_min = 1; lat_max = 1;
      mem_pend = 1'b0;
      @(negedge clock);

      // wrap of PC_STEP=4 from 0xFFFFFFFC and 2-bit count saturation
      do_reset(0);
      run(25);
      chk("wrap_n", acc4.size() >= 2, 1);
      if (acc4.size() >= 2) begin
         chk("wrap_a0", acc4[0], 32'hFFFF_FFFC);
         chk("wrap_a1", acc4[1], 32'h0000_0000);
      end
      chk("sat_count", instr_count4, 2'd3);

      // straight-line program ending in the halt word
      do_reset(0);
      imem_req_ready = 1'b1;
      run(20);
      chk("prog_n", consumed.size(), 3);
      foreach (consumed[i]) chk("prog_pc", consumed[i], i);
      chk("prog_halted", halted, 1);
      chk("prog_count", instr_count, 3);
      chk("prog_noreq", imem_req_valid, 0);

      // downstream stall while instr_pc=1
      do_reset(0);
      imem_req_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (instr_valid && instr_pc == 1) found = 1'b1;
         else run(1);
      end
      chk("stall_reach", found, 1);
      c0    = instr_count;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run(1);
         chk("stall_pc", instr_pc, 1);
         chk("stall_instr", instr, prog[1]);
         chk("stall_req", imem_req_valid, 0);
         chk("stall_cnt", instr_count, c0);
      end
      stall = 1'b0;
      run(1);
      chk("stall_next_req", imem_req_valid, 1);
      chk("stall_next_addr", imem_addr, 2);

      // redirect coinciding with the response for address 2
      do_reset(0);
      imem_req_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         redirect_valid = 1'b0;
         drive_mem();
         if (imem_rsp_valid && mem_addr == 2) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h40;
            found          = 1'b1;
         end
         cycle();
      end
      redirect_valid = 1'b0;
      chk("rdw_reach", found, 1);
      chk("rdw_req", imem_req_valid, 1);
      chk("rdw_addr", imem_addr, 32'h40);
      chk("rdw_iv", instr_valid, 0);

      // redirect in HOLD while stalled at instr_pc=5
      use_prog = 1'b0;
      do_reset(0);
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'd5;
      run(1);
      redirect_valid = 1'b0;
      stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid && instr_pc == 5) found = 1'b1;
         else run(1);
      end
      chk("rdh_reach", found, 1);
      c0 = instr_count;
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      run(1);
      redirect_valid = 1'b0; stall = 1'b0;
      chk("rdh_iv", instr_valid, 0);
      chk("rdh_req", imem_req_valid, 1);
      chk("rdh_addr", imem_addr, 32'h80);
      chk("rdh_cnt", instr_count, c0);

      // ready held low, then reset during WAIT with a late response
      do_reset(0);
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         run(1);
         chk("rdy_addr", imem_addr, 0);
      end
      imem_req_ready = 1'b1;
      run(1);
      imem_req_ready = 1'b0;
      do_reset(1);
      run(1);
      chk("late_iv", instr_valid, 0);
      imem_req_ready = 1'b1;
      run(8);

      // randomized traffic
      lat_min = 1; lat_max = 3;
      for (int r = 0; r < 8; r++) begin
         halt_addr = $urandom_range(40, 0);
         do_reset(0);
         for (int i = 0; i < 300; i++) begin
            imem_req_ready = ($urandom_range(9, 0) < 7);
            stall          = ($urandom_range(9, 0) < 3);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = $urandom_range(31, 0);
            run(1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
